alu_rs: RTL and testbench

Reservation station that feeds the ALU: it accepts decoded ALU/branch/load-store-address micro-ops from dispatch and holds them until both operands are available. It captures missing operands from the common data bus (CDB) and issues the oldest ready micro-op to the ALU as `op_func`/`oprand1`/`oprand2`. It sits between the rename/dispatch stage and the ALU execute stage, and is the producer side of the ALU operand interface.

---
 rtl/alu_rs_pkg.sv | 78 +++++++
 rtl/alu_rs_select.sv | 22 ++
 rtl/alu_rs.sv | 143 ++++++++++++++
 tb/tb_alu_rs.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared types, default widths and helpers for the ALU reservation station.
// The entry struct is sized by the RS_* constants below. If you build alu_rs with
// non-default widths, change these constants to match.
package alu_rs_pkg;

    localparam int RS_DEPTH         = 4;
    localparam int RS_OPRAND_WIDTH  = 32;
    localparam int RS_OP_FUNC_WIDTH = 17;
    localparam int RS_TAG_WIDTH     = 6;

    // op_func is packed as {funct7, funct3, opcode}
    localparam int OPCODE_LSB   = 0;
    localparam int OPCODE_WIDTH = 7;
    localparam int FUNCT3_LSB   = 7;
    localparam int FUNCT3_WIDTH = 3;
    localparam int FUNCT7_LSB   = 10;
    localparam int FUNCT7_WIDTH = 7;

    typedef enum logic [1:0] {
        ENTRY_EMPTY   = 2'd0,
        ENTRY_WAITING = 2'd1,
        ENTRY_READY   = 2'd2
    } entry_state_e;

    typedef struct packed {
        logic                        valid;
        logic [RS_OP_FUNC_WIDTH-1:0] op_func;
        logic [RS_TAG_WIDTH-1:0]     dest_tag;
        logic                        src1_rdy;
        logic [RS_OPRAND_WIDTH-1:0]  src1;
        logic                        src2_rdy;
        logic [RS_OPRAND_WIDTH-1:0]  src2;
    } rs_entry_t;

    // EMPTY / WAITING / READY is derived from the valid and ready bits
    function automatic entry_state_e entry_state(input rs_entry_t e);
        entry_state_e s;
        if (!e.valid)
            s = ENTRY_EMPTY;
        else if (e.src1_rdy && e.src2_rdy)
            s = ENTRY_READY;
        else
            s = ENTRY_WAITING;
        return s;
    endfunction

    // A pending source holds its producer tag in the low bits until the CDB delivers the value
    function automatic rs_entry_t wake_entry(input rs_entry_t                  e,
                                             input logic                       cdb_valid,
                                             input logic [RS_TAG_WIDTH-1:0]    cdb_tag,
                                             input logic [RS_OPRAND_WIDTH-1:0] cdb_data);
        rs_entry_t w;
        w = e;
        if (e.valid && cdb_valid) begin
            if (!e.src1_rdy && (e.src1[RS_TAG_WIDTH-1:0] == cdb_tag)) begin
                w.src1     = cdb_data;
                w.src1_rdy = 1'b1;
            end
            if (!e.src2_rdy && (e.src2[RS_TAG_WIDTH-1:0] == cdb_tag)) begin
                w.src2     = cdb_data;
                w.src2_rdy = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [RS_OP_FUNC_WIDTH-1:0] pack_op_func(input logic [FUNCT7_WIDTH-1:0] funct7,
                                                                 input logic [FUNCT3_WIDTH-1:0] funct3,
                                                                 input logic [OPCODE_WIDTH-1:0] opcode);
        logic [RS_OP_FUNC_WIDTH-1:0] f;
        f = '0;
        f[FUNCT7_LSB +: FUNCT7_WIDTH] = funct7;
        f[FUNCT3_LSB +: FUNCT3_WIDTH] = funct3;
        f[OPCODE_LSB +: OPCODE_WIDTH] = opcode;
        return f;
    endfunction

endpackage

// File: rtl/alu_rs_select.sv
// alu_rs_select: lowest-index-first priority picker; index 0 is the oldest entry.
module alu_rs_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic             any
);

    // Grant the first requesting slot scanning upward from the oldest
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && !any) begin
                grant[i] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the ALU, organised as a collapsing queue.
// Optional feature macro ALU_RS_WAKEUP_BYPASS_EN: when defined, an entry woken by the
// CDB can issue in the same cycle with cdb_data_i forwarded onto the operand outputs.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int DEPTH         = RS_DEPTH,
    parameter int OPRAND_WIDTH  = RS_OPRAND_WIDTH,
    parameter int OP_FUNC_WIDTH = RS_OP_FUNC_WIDTH,
    parameter int TAG_WIDTH     = RS_TAG_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     disp_valid_i,
    output logic                     disp_ready_o,
    input  logic [OP_FUNC_WIDTH-1:0] disp_op_func_i,
    input  logic [TAG_WIDTH-1:0]     disp_dest_tag_i,
    input  logic                     disp_src1_rdy_i,
    input  logic                     disp_src2_rdy_i,
    input  logic [OPRAND_WIDTH-1:0]  disp_src1_i,
    input  logic [OPRAND_WIDTH-1:0]  disp_src2_i,
    input  logic                     cdb_valid_i,
    input  logic [TAG_WIDTH-1:0]     cdb_tag_i,
    input  logic [OPRAND_WIDTH-1:0]  cdb_data_i,
    output logic                     issue_valid_o,
    input  logic                     issue_ready_i,
    output logic [OP_FUNC_WIDTH-1:0] op_func_o,
    output logic [OPRAND_WIDTH-1:0]  oprand1_o,
    output logic [OPRAND_WIDTH-1:0]  oprand2_o,
    output logic [TAG_WIDTH-1:0]     dest_tag_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    rs_entry_t        entries      [DEPTH];
    rs_entry_t        entries_next [DEPTH];
    rs_entry_t        upper        [DEPTH];
    rs_entry_t        cand         [DEPTH];
    rs_entry_t        disp_entry;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] wr_slot;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] grant;
    logic             any_ready;
    logic             disp_fire;
    logic             issue_fire;
    logic             passed;

    // The view select works from: stored state, or with bypass the state after this cycle's wakeup
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            cand[i] = wake_entry(entries[i], cdb_valid_i, cdb_tag_i, cdb_data_i);
`else
            cand[i] = entries[i];
`endif
            ready_vec[i] = (entry_state(cand[i]) == ENTRY_READY);
        end
    end

    alu_rs_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .req   (ready_vec),
        .grant (grant),
        .any   (any_ready)
    );

    assign issue_valid_o = any_ready && !flush_i;
    assign issue_fire    = issue_valid_o && issue_ready_i;
    assign disp_ready_o  = (count != CNT_W'(DEPTH));
    assign disp_fire     = disp_valid_i && disp_ready_o && !flush_i;

    // Drive the issue outputs from the granted entry; all zero when nothing is ready
    always_comb begin
        op_func_o  = '0;
        oprand1_o  = '0;
        oprand2_o  = '0;
        dest_tag_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                op_func_o  = cand[i].op_func;
                oprand1_o  = cand[i].src1;
                oprand2_o  = cand[i].src2;
                dest_tag_o = cand[i].dest_tag;
            end
        end
    end

    // Build the incoming entry, capturing a source that the CDB delivers in the dispatch cycle
    always_comb begin
        disp_entry.valid    = 1'b1;
        disp_entry.op_func  = disp_op_func_i;
        disp_entry.dest_tag = disp_dest_tag_i;
        disp_entry.src1_rdy = disp_src1_rdy_i;
        disp_entry.src1     = disp_src1_i;
        disp_entry.src2_rdy = disp_src2_rdy_i;
        disp_entry.src2     = disp_src2_i;
        disp_entry          = wake_entry(disp_entry, cdb_valid_i, cdb_tag_i, cdb_data_i);
    end

    // Neighbour above each slot, used when the queue collapses over an issued entry
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            upper[i] = entries[i + 1];
        end
        upper[DEPTH-1] = '0;
    end

    // Collapse over the issued entry first, then wake up at the new positions, then append the dispatch
    always_comb begin
        passed  = 1'b0;
        wr_slot = count - CNT_W'(issue_fire);
        for (int i = 0; i < DEPTH; i++) begin
            passed = passed | grant[i];
            if (issue_fire && passed)
                entries_next[i] = upper[i];
            else
                entries_next[i] = entries[i];
            entries_next[i] = wake_entry(entries_next[i], cdb_valid_i, cdb_tag_i, cdb_data_i);
            if (disp_fire && (CNT_W'(i) == wr_slot))
                entries_next[i] = disp_entry;
        end
        count_next = count + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end

    // Entry storage and occupancy; reset and flush both empty the station
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            count <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= entries_next[i];
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed test for alu_rs with hand-computed expected values.
module tb_alu_rs;

    localparam logic [16:0] OP_ADD = 17'b0000000_000_0110011;
    localparam logic [16:0] OP_SUB = 17'b0100000_000_0110011;

`ifdef ALU_RS_WAKEUP_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic        disp_valid_i;
    logic        disp_ready_o;
    logic [16:0] disp_op_func_i;
    logic [5:0]  disp_dest_tag_i;
    logic        disp_src1_rdy_i;
    logic        disp_src2_rdy_i;
    logic [31:0] disp_src1_i;
    logic [31:0] disp_src2_i;
    logic        cdb_valid_i;
    logic [5:0]  cdb_tag_i;
    logic [31:0] cdb_data_i;
    logic        issue_valid_o;
    logic        issue_ready_i;
    logic [16:0] op_func_o;
    logic [31:0] oprand1_o;
    logic [31:0] oprand2_o;
    logic [5:0]  dest_tag_o;

    int assert_count = 0;
    int fail_count   = 0;

    alu_rs dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .disp_valid_i    (disp_valid_i),
        .disp_ready_o    (disp_ready_o),
        .disp_op_func_i  (disp_op_func_i),
        .disp_dest_tag_i (disp_dest_tag_i),
        .disp_src1_rdy_i (disp_src1_rdy_i),
        .disp_src2_rdy_i (disp_src2_rdy_i),
        .disp_src1_i     (disp_src1_i),
        .disp_src2_i     (disp_src2_i),
        .cdb_valid_i     (cdb_valid_i),
        .cdb_tag_i       (cdb_tag_i),
        .cdb_data_i      (cdb_data_i),
        .issue_valid_o   (issue_valid_o),
        .issue_ready_i   (issue_ready_i),
        .op_func_o       (op_func_o),
        .oprand1_o       (oprand1_o),
        .oprand2_o       (oprand2_o),
        .dest_tag_o      (dest_tag_o)
    );

    // 10 ns clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Move to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive the dispatch port, then let combinational outputs settle
    task automatic apply_stimulus(input logic        valid,
                                  input logic [16:0] op,
                                  input logic [5:0]  dest,
                                  input logic        r1,
                                  input logic [31:0] s1,
                                  input logic        r2,
                                  input logic [31:0] s2);
        disp_valid_i    = valid;
        disp_op_func_i  = op;
        disp_dest_tag_i = dest;
        disp_src1_rdy_i = r1;
        disp_src1_i     = s1;
        disp_src2_rdy_i = r2;
        disp_src2_i     = s2;
        #2;
    endtask

    task automatic set_cdb(input logic valid, input logic [5:0] tag, input logic [31:0] data);
        cdb_valid_i = valid;
        cdb_tag_i   = tag;
        cdb_data_i  = data;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        flush_i       = 1'b0;
        issue_ready_i = 1'b0;
        set_cdb(1'b0, 6'd0, 32'd0);
        apply_stimulus(1'b0, 17'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Reset state
        check_output("rst_issue_valid", 32'(issue_valid_o), 32'd0);
        check_output("rst_disp_ready", 32'(disp_ready_o), 32'd1);
        check_output("rst_op_func", 32'(op_func_o), 32'd0);
        check_output("rst_oprand1", oprand1_o, 32'd0);
        check_output("rst_count", 32'(dut.count), 32'd0);
        tick();
        rst_i = 1'b0;

        // ADD, both sources ready
        $display("[TB] ADD with ready sources");
        issue_ready_i = 1'b1;
        apply_stimulus(1'b1, OP_ADD, 6'd3, 1'b1, 32'd5, 1'b1, 32'd7);
        check_output("add_not_yet", 32'(issue_valid_o), 32'd0);
        tick();
        apply_stimulus(1'b0, 17'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_output("add_valid", 32'(issue_valid_o), 32'd1);
        check_output("add_op_func", 32'(op_func_o), 32'h00033);
        check_output("add_oprand1", oprand1_o, 32'd5);
        check_output("add_oprand2", oprand2_o, 32'd7);
        check_output("add_dest", 32'(dest_tag_o), 32'd3);
        tick();
        #2;
        check_output("add_drained", 32'(issue_valid_o), 32'd0);
        check_output("add_count", 32'(dut.count), 32'd0);

        // SUB, src2 waits on tag 9
        $display("[TB] SUB with CDB wakeup");
        apply_stimulus(1'b1, OP_SUB, 6'd4, 1'b1, 32'h20, 1'b0, 32'd9);
        tick();
        issue_ready_i = 1'b0;
        apply_stimulus(1'b0, 17'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_output("sub_waiting", 32'(issue_valid_o), 32'd0);
        tick();
        set_cdb(1'b1, 6'd9, 32'h10);
        #2;
        check_output("sub_wake_cycle_valid", 32'(issue_valid_o), 32'(BYPASS));
        check_output("sub_wake_cycle_oprand2", oprand2_o, BYPASS ? 32'h10 : 32'h0);
        tick();
        set_cdb(1'b0, 6'd0, 32'd0);
        issue_ready_i = 1'b1;
        #2;
        check_output("sub_valid", 32'(issue_valid_o), 32'd1);
        check_output("sub_op_func", 32'(op_func_o), 32'h08033);
        check_output("sub_oprand1", oprand1_o, 32'h20);
        check_output("sub_oprand2", oprand2_o, 32'h10);
        check_output("sub_dest", 32'(dest_tag_o), 32'd4);
        tick();
        #2;
        check_output("sub_count", 32'(dut.count), 32'd0);

        // Fill all four entries while the ALU stalls
        $display("[TB] fill and full behaviour");
        issue_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b1, OP_ADD, 6'(10 + k), 1'b1, 32'(k), 1'b1, 32'(256 + k));
            check_output("fill_disp_ready", 32'(disp_ready_o), 32'd1);
            tick();
        end
        apply_stimulus(1'b1, OP_ADD, 6'd14, 1'b1, 32'h14, 1'b1, 32'h114);
        check_output("full_disp_ready", 32'(disp_ready_o), 32'd0);
        check_output("full_count", 32'(dut.count), 32'd4);
        check_output("full_oldest", 32'(dest_tag_o), 32'd10);
        tick();
        #2;
        check_output("full_rejected_count", 32'(dut.count), 32'd4);
        check_output("held_dest", 32'(dest_tag_o), 32'd10);
        check_output("held_oprand2", oprand2_o, 32'h100);
        issue_ready_i = 1'b1;
        #1;
        check_output("full_issue_disp_ready", 32'(disp_ready_o), 32'd0);
        tick();
        #2;
        check_output("after_issue_count", 32'(dut.count), 32'd3);
        check_output("after_issue_disp_ready", 32'(disp_ready_o), 32'd1);
        check_output("after_issue_dest", 32'(dest_tag_o), 32'd11);
        tick();
        apply_stimulus(1'b0, 17'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_output("disp_and_issue_count", 32'(dut.count), 32'd3);
        check_output("drain_dest_12", 32'(dest_tag_o), 32'd12);
        tick();
        #2;
        check_output("drain_dest_13", 32'(dest_tag_o), 32'd13);
        tick();
        #2;
        check_output("drain_dest_14", 32'(dest_tag_o), 32'd14);
        check_output("drain_oprand1_14", oprand1_o, 32'h14);
        check_output("drain_oprand2_14", oprand2_o, 32'h114);
        tick();
        #2;
        check_output("drain_empty", 32'(issue_valid_o), 32'd0);
        check_output("drain_count", 32'(dut.count), 32'd0);

        // Out-of-order: waiting, ready, waiting
        $display("[TB] oldest-ready selection");
        issue_ready_i = 1'b0;
        apply_stimulus(1'b1, OP_ADD, 6'd20, 1'b1, 32'd1, 1'b0, 32'd21);
        tick();
        apply_stimulus(1'b1, OP_ADD, 6'd22, 1'b1, 32'd2, 1'b1, 32'd3);
        tick();
        apply_stimulus(1'b1, OP_SUB, 6'd23, 1'b0, 32'd24, 1'b1, 32'd4);
        tick();
        issue_ready_i = 1'b1;
        apply_stimulus(1'b0, 17'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_output("ooo_first_valid", 32'(issue_valid_o), 32'd1);
        check_output("ooo_first_dest", 32'(dest_tag_o), 32'd22);
        tick();
        issue_ready_i = 1'b0;
        set_cdb(1'b1, 6'd21, 32'hAA);
        #2;
        check_output("ooo_wake0_valid", 32'(issue_valid_o), 32'(BYPASS));
        check_output("ooo_wake0_dest", 32'(dest_tag_o), BYPASS ? 32'd20 : 32'd0);
        tick();
        set_cdb(1'b0, 6'd0, 32'd0);
        issue_ready_i = 1'b1;
        #2;
        check_output("ooo_e0_dest", 32'(dest_tag_o), 32'd20);
        check_output("ooo_e0_oprand1", oprand1_o, 32'd1);
        check_output("ooo_e0_oprand2", oprand2_o, 32'hAA);
        tick();
        issue_ready_i = 1'b0;
        set_cdb(1'b1, 6'd24, 32'hBB);
        #2;
        check_output("ooo_wake2_dest", 32'(dest_tag_o), BYPASS ? 32'd23 : 32'd0);
        tick();
        set_cdb(1'b0, 6'd0, 32'd0);
        issue_ready_i = 1'b1;
        #2;
        check_output("ooo_e2_dest", 32'(dest_tag_o), 32'd23);
        check_output("ooo_e2_op_func", 32'(op_func_o), 32'h08033);
        check_output("ooo_e2_oprand1", oprand1_o, 32'hBB);
        check_output("ooo_e2_oprand2", oprand2_o, 32'd4);
        tick();
        #2;
        check_output("ooo_count", 32'(dut.count), 32'd0);

        // Dispatch-cycle capture from the CDB
        $display("[TB] dispatch-cycle capture");
        set_cdb(1'b1, 6'd31, 32'hCC);
        apply_stimulus(1'b1, OP_ADD, 6'd30, 1'b0, 32'd31, 1'b1, 32'd6);
        check_output("cap_not_yet", 32'(issue_valid_o), 32'd0);
        tick();
        set_cdb(1'b0, 6'd0, 32'd0);
        apply_stimulus(1'b0, 17'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_output("cap_valid", 32'(issue_valid_o), 32'd1);
        check_output("cap_oprand1", oprand1_o, 32'hCC);
        check_output("cap_oprand2", oprand2_o, 32'd6);
        check_output("cap_dest", 32'(dest_tag_o), 32'd30);
        tick();
        #2;
        check_output("cap_count", 32'(dut.count), 32'd0);

        // Flush with three entries
        $display("[TB] flush");
        issue_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, OP_ADD, 6'(40 + k), 1'b1, 32'(k), 1'b1, 32'(k));
            tick();
        end
        flush_i       = 1'b1;
        issue_ready_i = 1'b1;
        apply_stimulus(1'b1, OP_ADD, 6'd43, 1'b1, 32'd9, 1'b1, 32'd9);
        check_output("flush_issue_valid", 32'(issue_valid_o), 32'd0);
        check_output("flush_pre_count", 32'(dut.count), 32'd3);
        tick();
        flush_i = 1'b0;
        apply_stimulus(1'b0, 17'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_output("flush_count", 32'(dut.count), 32'd0);
        check_output("flush_after_valid", 32'(issue_valid_o), 32'd0);
        check_output("flush_disp_ready", 32'(disp_ready_o), 32'd1);

        // Asynchronous reset in the middle of a cycle
        $display("[TB] mid-stream reset");
        issue_ready_i = 1'b0;
        apply_stimulus(1'b1, OP_ADD, 6'd50, 1'b1, 32'd1, 1'b1, 32'd2);
        tick();
        apply_stimulus(1'b1, OP_ADD, 6'd51, 1'b1, 32'd3, 1'b1, 32'd4);
        tick();
        apply_stimulus(1'b0, 17'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_output("prerst_valid", 32'(issue_valid_o), 32'd1);
        check_output("prerst_dest", 32'(dest_tag_o), 32'd50);
        rst_i = 1'b1;
        #1;
        check_output("async_rst_valid", 32'(issue_valid_o), 32'd0);
        check_output("async_rst_count", 32'(dut.count), 32'd0);
        check_output("async_rst_dest", 32'(dest_tag_o), 32'd0);
        check_output("async_rst_disp_ready", 32'(disp_ready_o), 32'd1);
        tick();
        rst_i = 1'b0;
        #2;
        check_output("post_rst_valid", 32'(issue_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
